uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//   Parametrised UART serial transmitter that replaces the fixed 8N1 transmitter.
//   Takes parallel words through a valid/ready handshake and serialises each one LSB-first on txd.
//   Frame on the line: start bit, data bits, optional parity bit, then 1 or 2 stop bits.
//   Sits between the word source (register or FIFO) and the board TX pin.
// PARAMETERS
//   DATA_W        8   data bits per frame; legal range 5..9
//   CLKS_PER_BIT  16  clk cycles per bit period; must be >= 2
//   PARITY        0   0 = none, 1 = even, 2 = odd
//   STOP_BITS     1   number of stop bits; legal values 1 or 2
// PORTS
//   clk       in   1       system clock; all logic on the rising edge
//   rst       in   1       asynchronous, active-low reset
//   tx_data   in   DATA_W  word to transmit; sampled only on accept
//   tx_valid  in   1       source has a word on tx_data
//   tx_ready  out  1       transmitter can accept a word (high in IDLE only)
//   txd       out  1       serial line; idles high
//   busy      out  1       frame in progress (high whenever state != IDLE)
// BEHAVIOUR
//   Reset (rst=0, asynchronous)
//     - Outputs: txd=1, tx_ready=1, busy=0.
//     - State = IDLE; bit counter and baud counter = 0.
//     - Mid-frame reset aborts the frame at once; the line returns high with no partial stop bit.
//   Handshake
//     - Accept occurs on the clk edge where tx_valid & tx_ready.
//     - tx_data is latched into a shift register on accept.
//     - Later changes to tx_data do not affect the frame in flight.
//     - tx_valid while busy is ignored: no queuing, no error.
//   State machine (IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE)
//     - IDLE:   txd=1; on accept go to START.
//     - START:  txd=0 for CLKS_PER_BIT cycles.
//     - DATA:   txd = shift[0]; after each CLKS_PER_BIT cycles, shift right; DATA_W bits total.
//     - PARITY: present only if PARITY != 0. txd = ^data for even, ~^data for odd; lasts CLKS_PER_BIT cycles.
//     - STOP:   txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//   Timing
//     - txd is registered.
//     - Start bit appears on the first cycle after the accept edge.
//     - Each bit holds exactly CLKS_PER_BIT cycles.
//     - tx_ready rises in the cycle after the last stop cycle.
//     - Frame period = (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT + 1 cycles.
//     - Back-to-back frames: valid held high gives that period exactly, with no extra idle.
//   Counter and width rules
//     - Baud counter width = $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, wraps at the end of each bit.
//     - Bit counter width = $clog2(DATA_W+1).
//   Invalid parameters
//     - Elaboration-time $error if DATA_W, PARITY, STOP_BITS or CLKS_PER_BIT is out of range.
// TESTING
//   1. Baseline 8N1 (DATA_W=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1), send 0x81
//      -> txd = 0,1,0,0,0,0,0,0,1,1, each bit held 4 cycles; tx_ready=0 for 40 cycles, then 1.
//   2. PARITY=1 (even), send 0x81 -> parity bit 0.
//      PARITY=2 (odd), send 0x81 -> parity bit 1.
//      PARITY=1, send 0x07 -> parity bit 1.
//      Frame length 11 bits = 44 cycles.
//   3. Accept 0x81, then drive tx_data=0x00 two cycles later and hold tx_valid high
//      -> first frame still carries 0x81; second frame carries 0x00 and starts exactly 41 cycles after the first accept.
//   4. STOP_BITS=2, DATA_W=5, send 5'h15 -> txd = 0,1,0,1,0,1,1,1; line high for 8 cycles before tx_ready=1.
//   5. Pull rst low during data bit 3 -> txd=1, busy=0, tx_ready=1 in the same cycle (async).
//      After release, a new word 0x3C transmits a clean, correct frame.
//   6. tx_valid pulsed while busy -> the word is dropped; current frame is unchanged; no second frame follows.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Accepts one word per valid/ready handshake (only while idle) and shifts it
// out LSB-first as start bit, DATA_W data bits, optional parity bit and
// STOP_BITS stop bits, each bit lasting CLKS_PER_BIT clock cycles.
// All outputs are registered; txd idles high.
module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy
);

  // Counter widths; the baud counter never drops below one bit even for
  // the smallest legal bit period.
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(32'd1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(32'd1);

  // Reject configurations the frame format cannot represent.
  if ((DATA_W < 5) || (DATA_W > 9)) begin : g_bad_data_w
    $error("uart_tx_frame: DATA_W must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity bit for a word: even parity makes the total count of ones even,
  // odd parity makes it odd. Computed once at accept time.
  function automatic logic calc_parity(input logic [DATA_W-1:0] data);
    logic result;
    if (PARITY == 2) begin
      result = ~^data;
    end else begin
      result = ^data;
    end
    return result;
  endfunction

  state_t              state_r, state_s;
  logic [BAUD_W-1:0]   baud_r, baud_s;
  logic [BIT_W-1:0]    bit_r, bit_s;
  logic [DATA_W-1:0]   shift_r, shift_s;
  logic                par_r, par_s;
  logic                txd_r, txd_s;
  logic                tx_ready_r;
  logic                busy_r;
  logic                bit_end_s;

  assign bit_end_s = (baud_r == BAUD_LAST);
  assign tx_ready  = tx_ready_r;
  assign txd       = txd_r;
  assign busy      = busy_r;

  // Next-state logic: sequences the frame fields and the baud/bit counters.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    par_s   = par_r;
    case (state_r)
      ST_IDLE: begin
        baud_s = {BAUD_W{1'b0}};
        bit_s  = {BIT_W{1'b0}};
        if (tx_valid && tx_ready_r) begin
          state_s = ST_START;
          shift_s = tx_data;
          par_s   = calc_parity(tx_data);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_s  = {BAUD_W{1'b0}};
          bit_s   = {BIT_W{1'b0}};
          state_s = ST_DATA;
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_s  = {BAUD_W{1'b0}};
          shift_s = shift_r >> 1;
          if (bit_r == DATA_LAST) begin
            bit_s   = {BIT_W{1'b0}};
            state_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_s = bit_r + BIT_ONE;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          baud_s  = {BAUD_W{1'b0}};
          bit_s   = {BIT_W{1'b0}};
          state_s = ST_STOP;
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          baud_s = {BAUD_W{1'b0}};
          if (bit_r == STOP_LAST) begin
            bit_s   = {BIT_W{1'b0}};
            state_s = ST_IDLE;
          end else begin
            bit_s = bit_r + BIT_ONE;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        baud_s  = {BAUD_W{1'b0}};
        bit_s   = {BIT_W{1'b0}};
      end
    endcase
  end

  // Line level for the coming cycle, decoded from the next state so txd can
  // be registered without adding a cycle of latency.
  always_comb begin
    txd_s = 1'b1;
    case (state_s)
      ST_IDLE:   txd_s = 1'b1;
      ST_START:  txd_s = 1'b0;
      ST_DATA:   txd_s = shift_s[0];
      ST_PARITY: txd_s = par_s;
      ST_STOP:   txd_s = 1'b1;
      default:   txd_s = 1'b1;
    endcase
  end

  // State, counters, data and registered outputs; reset aborts any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      baud_r     <= {BAUD_W{1'b0}};
      bit_r      <= {BIT_W{1'b0}};
      shift_r    <= {DATA_W{1'b0}};
      par_r      <= 1'b0;
      txd_r      <= 1'b1;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_r     <= baud_s;
      bit_r      <= bit_s;
      shift_r    <= shift_s;
      par_r      <= par_s;
      txd_r      <= txd_s;
      tx_ready_r <= (state_s == ST_IDLE);
      busy_r     <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four transmitter configurations (8N1, 8E1, 8O1 with a
// 3-cycle bit, 5N2) checked cycle by cycle against a frame model built from
// the frame layout rules.
module tb_uart_tx_frame;

  localparam int NDUT = 4;
  localparam int CFG_DW  [NDUT] = '{8, 8, 8, 5};
  localparam int CFG_CPB [NDUT] = '{4, 4, 3, 4};
  localparam int CFG_PAR [NDUT] = '{0, 1, 2, 0};
  localparam int CFG_SB  [NDUT] = '{1, 1, 2 - 1, 2};

  logic clk;
  logic rst;
  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic [NDUT-1:0] valid_v;
  logic [NDUT-1:0] ready_v;
  logic [NDUT-1:0] txd_v;
  logic [NDUT-1:0] busy_v;

  int checks;
  int errors;

  uart_tx_frame #(.DATA_W(CFG_DW[0]), .CLKS_PER_BIT(CFG_CPB[0]), .PARITY(CFG_PAR[0]), .STOP_BITS(CFG_SB[0])) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]));
  uart_tx_frame #(.DATA_W(CFG_DW[1]), .CLKS_PER_BIT(CFG_CPB[1]), .PARITY(CFG_PAR[1]), .STOP_BITS(CFG_SB[1])) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]));
  uart_tx_frame #(.DATA_W(CFG_DW[2]), .CLKS_PER_BIT(CFG_CPB[2]), .PARITY(CFG_PAR[2]), .STOP_BITS(CFG_SB[2])) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]));
  uart_tx_frame #(.DATA_W(CFG_DW[3]), .CLKS_PER_BIT(CFG_CPB[3]), .PARITY(CFG_PAR[3]), .STOP_BITS(CFG_SB[3])) u_dut3 (
    .clk(clk), .rst(rst), .tx_data(d3), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .txd(txd_v[3]), .busy(busy_v[3]));

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int d, input logic [8:0] w, input logic v);
    case (d)
      0: d0 = w[7:0];
      1: d1 = w[7:0];
      2: d2 = w[7:0];
      default: d3 = w[4:0];
    endcase
    valid_v[d] = v;
  endtask

  function automatic int frame_len(input int d);
    return (1 + CFG_DW[d] + ((CFG_PAR[d] != 0) ? 1 : 0) + CFG_SB[d]) * CFG_CPB[d];
  endfunction

  // Expected line level k cycles after the accept edge.
  function automatic logic exp_bit(input int d, input logic [8:0] w, input int k);
    int idx;
    int ones;
    idx  = k / CFG_CPB[d];
    ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= CFG_DW[d]) return w[idx-1];
    if ((CFG_PAR[d] != 0) && (idx == CFG_DW[d] + 1)) begin
      for (int i = 0; i < CFG_DW[d]; i++) ones += int'(w[i]);
      if (CFG_PAR[d] == 1) return ((ones % 2) == 1);
      return ((ones % 2) == 0);
    end
    return 1'b1;
  endfunction

  function automatic logic [2:0] line_state(input int d);
    return {txd_v[d], ready_v[d], busy_v[d]};
  endfunction

  // Expect the transmitter to sit idle for n cycles.
  task automatic idle_chk(input int d, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_idle_d%0d_%0d", tag, d, i), 32'(line_state(d)), 32'(3'b110));
    end
  endtask

  // Send one word (starting at a negedge with the DUT idle), check every
  // cycle of the frame plus the idle cycle after it. At cycle ev_k an event
  // drives (ev_v, ev_w); without hold the valid is a one-cycle pulse.
  task automatic frame(input int d, input logic [8:0] w, input bit hold,
                       input int ev_k, input bit ev_v, input logic [8:0] ev_w, input string tag);
    int len;
    len = frame_len(d);
    set_in(d, w, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_in(d, w, 1'b0);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check($sformatf("%s_d%0d_k%0d", tag, d, k), 32'(line_state(d)), 32'({exp_bit(d, w, k), 1'b0, 1'b1}));
      if (k == ev_k) begin
        set_in(d, ev_w, ev_v);
      end else if ((ev_k >= 0) && (k == ev_k + 1) && !hold) begin
        set_in(d, ev_w, 1'b0);
      end
    end
    @(negedge clk);
    check($sformatf("%s_end_d%0d", tag, d), 32'(line_state(d)), 32'(3'b110));
  endtask

  initial begin
    logic [8:0] w;
    bit hold;
    int gap;
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 5'h00;
    valid_v = 4'b0000;

    // Reset state on every configuration.
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) check($sformatf("reset_d%0d", d), 32'(line_state(d)), 32'(3'b110));
    rst = 1'b1;
    idle_chk(0, 2, "post_reset");

    // Directed frames: 8N1, even/odd parity, 5-bit with two stop bits.
    frame(0, 9'h081, 1'b0, -1, 1'b0, 9'h000, "n81");
    frame(1, 9'h081, 1'b0, -1, 1'b0, 9'h000, "even81");
    frame(2, 9'h081, 1'b0, -1, 1'b0, 9'h000, "odd81");
    frame(1, 9'h007, 1'b0, -1, 1'b0, 9'h000, "even07");
    frame(3, 9'h015, 1'b0, -1, 1'b0, 9'h000, "n52");

    // Data changed after accept with valid held: frames back to back, 41 cycles apart.
    frame(0, 9'h081, 1'b1, 1, 1'b1, 9'h000, "b2b_a");
    frame(0, 9'h000, 1'b0, -1, 1'b0, 9'h000, "b2b_b");

    // Valid pulse while busy is dropped.
    frame(0, 9'h0A5, 1'b0, 10, 1'b1, 9'h05A, "drop");
    idle_chk(0, 12, "drop");

    // Asynchronous reset during data bit 3, then a clean frame.
    w = 9'h0F0;
    set_in(0, w, 1'b1);
    @(posedge clk);
    #1;
    set_in(0, w, 1'b0);
    for (int k = 0; k < 18; k++) @(negedge clk);
    check("pre_rst_bit3", 32'(line_state(0)), 32'({exp_bit(0, w, 17), 1'b0, 1'b1}));
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", 32'(line_state(0)), 32'(3'b110));
    @(negedge clk);
    rst = 1'b1;
    idle_chk(0, 2, "after_rst");
    frame(0, 9'h03C, 1'b0, -1, 1'b0, 9'h000, "rst_3c");

    // Randomised frames, occasionally back to back.
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 6; n++) begin
        w    = 9'($urandom_range(0, (1 << CFG_DW[d]) - 1));
        hold = (n < 5) && ($urandom_range(0, 2) == 0);
        frame(d, w, hold, -1, 1'b0, 9'h000, "rnd");
        if (!hold) begin
          gap = $urandom_range(0, 3);
          if (gap > 0) idle_chk(d, gap, "rnd");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
